line_delay_ctrl: RTL

- Sequences one external synchronous FIFO (2048x16, read latency 1 cycle, no output register) as a one-line pixel delay for the image filter's window generator.
- Writes each incoming pixel into the FIFO. Once a full line is buffered, it reads one pixel per written pixel, so the current-line and previous-line pixels leave the block column-aligned.
- Handles frame restart by draining stale FIFO contents. Reports protocol errors through sticky flags.

---
 rtl/line_delay_ctrl.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/line_delay_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : line_delay_ctrl
//  Description : Sequences one external synchronous FIFO (read latency 1, no
//                output register) as a one-line pixel delay. The first line
//                of a frame is written only; each later pixel writes one
//                entry and reads one entry, so current-line and previous-line
//                pixels leave the block column-aligned. A start-of-frame
//                drains stale FIFO contents before the next frame is filled.
//  Ports       : clk, rst (sync, active-high)
//                sof, in_valid, in_data            - pixel input side
//                fifo_wr_en/wr_data/full,
//                fifo_rd_en/rd_data/empty          - external FIFO
//                out_valid, out_cur, out_prev, out_prev_valid,
//                out_col, out_eol                  - column-aligned output
//                err_ovf, err_unf, err_drop        - sticky protocol errors
//  Revision    : 1.0 - initial release
// ============================================================================
module line_delay_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int IMG_WIDTH  = 1920,
  parameter int COL_WIDTH  = 11
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sof,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  fifo_wr_en,
  output logic [DATA_WIDTH-1:0] fifo_wr_data,
  input  logic                  fifo_full,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                  fifo_empty,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_cur,
  output logic [DATA_WIDTH-1:0] out_prev,
  output logic                  out_prev_valid,
  output logic [COL_WIDTH-1:0]  out_col,
  output logic                  out_eol,
  output logic                  err_ovf,
  output logic                  err_unf,
  output logic                  err_drop
);

  localparam logic [COL_WIDTH-1:0] COL_LAST = COL_WIDTH'(IMG_WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRAIN = 2'd1,
    S_FILL  = 2'd2,
    S_RUN   = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [COL_WIDTH-1:0]   col_q, col_d;

  logic                   out_valid_q, out_prev_valid_q, out_eol_q;
  logic [DATA_WIDTH-1:0]  out_cur_q;
  logic [COL_WIDTH-1:0]   out_col_q;
  logic                   err_ovf_q, err_unf_q, err_drop_q;
  logic                   err_ovf_d, err_unf_d, err_drop_d;

  logic                   accept_c;   // pixel taken into the line pipeline
  logic                   in_run_c;
  logic                   rd_en_c;
  logic                   col_last_c;

  assign col_last_c = (col_q == COL_LAST);

  // --------------------------------------------------------------------------
  // Next-state, column and FIFO strobes
  // --------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    accept_c = 1'b0;
    in_run_c = 1'b0;
    rd_en_c  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (sof) state_d = S_DRAIN;
      end

      S_DRAIN: begin
        rd_en_c = !fifo_empty;
        if (fifo_empty) begin
          state_d = S_FILL;
          col_d   = '0;
        end
      end

      S_FILL: begin
        accept_c = in_valid;
        if (in_valid) begin
          if (col_last_c) begin
            col_d   = '0;
            state_d = S_RUN;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
        // The pixel of this cycle is still handled above; sof only redirects
        // the state for the following cycle.
        if (sof) state_d = S_DRAIN;
      end

      S_RUN: begin
        accept_c = in_valid;
        in_run_c = 1'b1;
        // One read per write keeps occupancy at exactly one line.
        rd_en_c  = in_valid;
        if (in_valid) begin
          col_d = col_last_c ? '0 : col_q + 1'b1;
        end
        if (sof) state_d = S_DRAIN;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Sticky error flags
  // --------------------------------------------------------------------------
  always_comb begin
    err_ovf_d  = err_ovf_q  | (in_valid & fifo_full);
    err_unf_d  = err_unf_q  | (in_run_c & in_valid & fifo_empty);
    err_drop_d = err_drop_q | (in_valid & ((state_q == S_IDLE) | (state_q == S_DRAIN)));
  end

  // --------------------------------------------------------------------------
  // State, column, output pipeline and error registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= S_IDLE;
      col_q            <= '0;
      out_valid_q      <= 1'b0;
      out_cur_q        <= '0;
      out_col_q        <= '0;
      out_eol_q        <= 1'b0;
      out_prev_valid_q <= 1'b0;
      err_ovf_q        <= 1'b0;
      err_unf_q        <= 1'b0;
      err_drop_q       <= 1'b0;
    end else begin
      state_q          <= state_d;
      col_q            <= col_d;
      out_valid_q      <= accept_c;
      out_cur_q        <= in_data;
      out_col_q        <= col_q;
      out_eol_q        <= accept_c & col_last_c;
      out_prev_valid_q <= accept_c & in_run_c;
      err_ovf_q        <= err_ovf_d;
      err_unf_q        <= err_unf_d;
      err_drop_q       <= err_drop_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign fifo_wr_data = in_data;
  // A full FIFO blocks the write but the pixel still travels down the pipe.
  assign fifo_wr_en   = accept_c & !fifo_full;
  assign fifo_rd_en   = rd_en_c;

  assign out_valid      = out_valid_q;
  assign out_cur        = out_cur_q;
  assign out_col        = out_col_q;
  assign out_eol        = out_eol_q;
  assign out_prev_valid = out_prev_valid_q;
  // The FIFO word read alongside a pixel arrives exactly when that pixel is
  // presented on out_cur, so it is passed through rather than re-registered.
  assign out_prev       = out_prev_valid_q ? fifo_rd_data : '0;

  assign err_ovf  = err_ovf_q;
  assign err_unf  = err_unf_q;
  assign err_drop = err_drop_q;

endmodule
`default_nettype wire
